// File: rtl/rbr_pkg.sv
// Shared types and pure helper functions for the thermometer-to-RBR encoder.
// Functions take codes zero-extended to MAX_W bits plus the live width.
package rbr_pkg;

  typedef enum logic {
    RBR_STRICT = 1'b0,
    RBR_BUBBLE = 1'b1
  } rbr_mode_e;

  localparam int MAX_W = 32;

  function automatic int default_lut_entry(int level, int therm_w, int out_w);
    int cap;
    int d;
    int res;
    cap = (1 << out_w) - 1;
    d   = therm_w - level;
    res = (d < cap) ? d : cap;
    if (therm_w == 8 && out_w == 4) begin
      case (level)
        0, 1:    res = 9;
        2, 3:    res = 6;
        4:       res = 4;
        5:       res = 3;
        6:       res = 2;
        7:       res = 1;
        default: res = 0;
      endcase
    end
    return res;
  endfunction

  // Strict codes are a run of ones from the MSB followed only by zeros.
  function automatic logic therm_is_valid(logic [MAX_W-1:0] code, int w);
    logic seen_zero;
    logic ok;
    seen_zero = 1'b0;
    ok        = 1'b1;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (i < w) begin
        if (!code[i]) seen_zero = 1'b1;
        else if (seen_zero) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  function automatic int leading_ones(logic [MAX_W-1:0] code, int w);
    int  n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (i < w) begin
        if (run && code[i]) n++;
        else run = 1'b0;
      end
    end
    return n;
  endfunction

  function automatic int popcount(logic [MAX_W-1:0] code, int w);
    int n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) n += int'(code[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/rbr_ch_decode.sv
// Combinational per-channel decode: thermometer code to level plus a code-valid flag.
module rbr_ch_decode
  import rbr_pkg::*;
#(
  parameter int THERM_W = 8,
  parameter int LVL_W   = 4
) (
  input  logic [THERM_W-1:0] code,
  input  rbr_mode_e          mode,
  output logic [LVL_W-1:0]   level,
  output logic               code_ok
);

  logic [MAX_W-1:0] code_ext;

  assign code_ext = MAX_W'(code);

  // NOTE: every output gets a default first so no path through the block can infer a latch.
  always_comb begin
    level   = '0;
    code_ok = 1'b1;
    if (mode == RBR_BUBBLE) begin
      level = LVL_W'(popcount(code_ext, THERM_W));
    end else begin
      level   = LVL_W'(leading_ones(code_ext, THERM_W));
      code_ok = therm_is_valid(code_ext, THERM_W);
    end
  end

endmodule

// File: rtl/rbr_thermo_encoder.sv
// Multi-channel thermometer encoder: decode, programmable LUT map, saturating
// batch accumulation and a registered valid/ready result port.
module rbr_thermo_encoder
  import rbr_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  int THERM_W = 8,
  parameter  int OUT_W   = 4,
  parameter  int ACC_W   = 8,
  localparam int LVL_W   = $clog2(THERM_W + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [NUM_CH*THERM_W-1:0] therm_i,
  input  logic                      mode_i,
  input  logic [3:0]                accum_len_i,
  input  logic                      lut_we_i,
  input  logic [LVL_W-1:0]          lut_addr_i,
  input  logic [OUT_W-1:0]          lut_data_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [NUM_CH*ACC_W-1:0]   value_o,
  output logic [NUM_CH-1:0]         err_o
);

  logic [OUT_W-1:0]               lut [THERM_W+1];
  logic [NUM_CH-1:0][ACC_W-1:0]   acc;
  logic [NUM_CH-1:0][ACC_W-1:0]   sum;
  logic [NUM_CH-1:0]              err_acc;
  logic [NUM_CH-1:0]              bad;
  logic [3:0]                     cnt;
  logic [3:0]                     batch_len;
  logic [3:0]                     eff_len;
  logic                           accept;
  logic                           last;
  logic                           consume;

  assign ready_o = !(valid_o && !ready_i);
  assign accept  = valid_i && ready_o;
  assign consume = valid_o && ready_i;

  // The batch length is only live-sampled on the first sample of a batch.
  assign eff_len = (cnt != 4'd0) ? batch_len :
                   (accum_len_i == 4'd0) ? 4'd1 : accum_len_i;
  assign last    = accept && (({1'b0, cnt} + 5'd1) == {1'b0, eff_len});

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [LVL_W-1:0] level;
    logic             code_ok;
    logic [OUT_W-1:0] mapped;
    logic [ACC_W:0]   wide;

    rbr_ch_decode #(
      .THERM_W (THERM_W),
      .LVL_W   (LVL_W)
    ) u_dec (
      .code    (therm_i[c*THERM_W +: THERM_W]),
      .mode    (rbr_mode_e'(mode_i)),
      .level   (level),
      .code_ok (code_ok)
    );

    assign mapped = code_ok ? lut[level] : '0;
    assign bad[c] = !code_ok;
    assign wide   = {1'b0, acc[c]} + (ACC_W+1)'(mapped);
    assign sum[c] = wide[ACC_W] ? '1 : wide[ACC_W-1:0];
  end

  // NOTE: the LUT is a small register file, so it can be reset to its default table;
  // a true RAM macro could not be and would need an init sequence instead.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i <= THERM_W; i++) begin
        lut[i] <= OUT_W'(default_lut_entry(i, THERM_W, OUT_W));
      end
      acc       <= '0;
      err_acc   <= '0;
      cnt       <= '0;
      batch_len <= 4'd1;
      valid_o   <= 1'b0;
      value_o   <= '0;
      err_o     <= '0;
    end else begin
      // NOTE: non-blocking updates let a same-cycle sample read the old LUT entry.
      if (lut_we_i && (lut_addr_i <= LVL_W'(THERM_W))) begin
        lut[lut_addr_i] <= lut_data_i;
      end

      if (accept && cnt == 4'd0) batch_len <= eff_len;

      if (last) begin
        acc     <= '0;
        err_acc <= '0;
        cnt     <= '0;
        value_o <= sum;
        err_o   <= err_acc | bad;
        valid_o <= 1'b1;
      end else begin
        if (accept) begin
          acc     <= sum;
          err_acc <= err_acc | bad;
          cnt     <= cnt + 4'd1;
        end
        if (consume) valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rbr_thermo_encoder.sv
// Directed bench for rbr_thermo_encoder; a second instance with ACC_W=7 covers saturation.
module tb_rbr_thermo_encoder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic [31:0] therm_i;
  logic        mode_i;
  logic [3:0]  accum_len_i;
  logic        lut_we_i;
  logic [3:0]  lut_addr_i;
  logic [3:0]  lut_data_i;
  logic        ready_i;

  logic        ready8, valid8, ready7, valid7;
  logic [31:0] value8;
  logic [27:0] value7;
  logic [3:0]  err8, err7;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  rbr_thermo_encoder dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .ready_o     (ready8),
    .therm_i     (therm_i),
    .mode_i      (mode_i),
    .accum_len_i (accum_len_i),
    .lut_we_i    (lut_we_i),
    .lut_addr_i  (lut_addr_i),
    .lut_data_i  (lut_data_i),
    .valid_o     (valid8),
    .ready_i     (ready_i),
    .value_o     (value8),
    .err_o       (err8)
  );

  rbr_thermo_encoder #(.ACC_W(7)) dut7 (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .ready_o     (ready7),
    .therm_i     (therm_i),
    .mode_i      (mode_i),
    .accum_len_i (accum_len_i),
    .lut_we_i    (lut_we_i),
    .lut_addr_i  (lut_addr_i),
    .lut_data_i  (lut_data_i),
    .valid_o     (valid7),
    .ready_i     (ready_i),
    .value_o     (value7),
    .err_o       (err7)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [31:0] t, input logic m, input logic [3:0] len);
    therm_i     = t;
    mode_i      = m;
    accum_len_i = len;
    valid_i     = 1'b1;
    tick();
    valid_i     = 1'b0;
  endtask

  initial begin
    rst_ni      = 1'b0;
    valid_i     = 1'b0;
    therm_i     = '0;
    mode_i      = 1'b0;
    accum_len_i = 4'd1;
    lut_we_i    = 1'b0;
    lut_addr_i  = '0;
    lut_data_i  = '0;
    ready_i     = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_valid", 64'(valid8), 64'(0));
    check("rst_value", 64'(value8), 64'(0));
    check("rst_err",   64'(err8),   64'(0));
    check("rst_ready", 64'(ready8), 64'(1));
    rst_ni = 1'b1;
    tick();

    // Strict, len 1, level 4 on all lanes
    send(32'hF0F0F0F0, 1'b0, 4'd1);
    check("strict_valid", 64'(valid8), 64'(1));
    check("strict_value", 64'(value8), 64'(32'h04040404));
    check("strict_err",   64'(err8),   64'(0));
    tick();
    check("strict_drop",  64'(valid8), 64'(0));

    // Invalid strict code on ch0, all-ones elsewhere (level 8 -> 0)
    send(32'hFFFFFFA0, 1'b0, 4'd1);
    check("bad_value", 64'(value8), 64'(0));
    check("bad_err",   64'(err8),   64'(4'b0001));
    send(32'hF0F0F0F0, 1'b0, 4'd1);
    check("bad_clear_err",   64'(err8),   64'(0));
    check("bad_clear_value", 64'(value8), 64'(32'h04040404));

    // Bubble mode: ch1 popcount 2 -> 6, others level 0 -> 9
    send(32'h0000A000, 1'b1, 4'd1);
    check("bubble_value", 64'(value8), 64'(32'h09090609));
    check("bubble_err",   64'(err8),   64'(0));

    // Accumulate 3 samples; mid-batch length change to 5 ignored
    send(32'h00000000, 1'b0, 4'd3);
    check("acc_s1_valid", 64'(valid8), 64'(0));
    send(32'h00C00000, 1'b0, 4'd5);
    check("acc_s2_valid", 64'(valid8), 64'(0));
    send(32'h00FE0000, 1'b0, 4'd5);
    check("acc_valid", 64'(valid8), 64'(1));
    check("acc_value", 64'(value8), 64'(32'h1B101B1B));

    // Length 0 behaves as 1
    send(32'h00000000, 1'b0, 4'd0);
    check("len0_valid", 64'(valid8), 64'(1));
    check("len0_value", 64'(value8), 64'(32'h09090909));

    // LUT write in the same cycle as a sample: old entry used
    lut_we_i = 1'b1; lut_addr_i = 4'd8; lut_data_i = 4'd15;
    send(32'hFFFFFFFF, 1'b0, 4'd1);
    lut_we_i = 1'b0;
    check("lut_same_cycle", 64'(value8), 64'(0));
    send(32'hFFFFFFFF, 1'b0, 4'd1);
    check("lut_new_entry", 64'(value8), 64'(32'h0F0F0F0F));
    lut_we_i = 1'b1; lut_addr_i = 4'd9; lut_data_i = 4'd7;
    tick();
    lut_we_i = 1'b0;
    send(32'hFFFFFFFF, 1'b0, 4'd1);
    check("lut_addr9_ignored", 64'(value8), 64'(32'h0F0F0F0F));
    send(32'h00000000, 1'b0, 4'd1);
    check("lut_entry0_kept", 64'(value8), 64'(32'h09090909));

    // Backpressure: result held, input stalls, no sample lost
    ready_i = 1'b0;
    send(32'h00000000, 1'b0, 4'd1);
    check("bp_valid", 64'(valid8), 64'(1));
    therm_i = 32'hFFFFFFFF; valid_i = 1'b1;
    check("bp_ready_low", 64'(ready8), 64'(0));
    tick();
    check("bp_hold_valid", 64'(valid8), 64'(1));
    check("bp_hold_value", 64'(value8), 64'(32'h09090909));
    ready_i = 1'b1;
    #1;
    check("bp_ready_high", 64'(ready8), 64'(1));
    tick();
    valid_i = 1'b0;
    check("bp_reload_valid", 64'(valid8), 64'(1));
    check("bp_reload_value", 64'(value8), 64'(32'h0F0F0F0F));
    tick();
    check("bp_consumed", 64'(valid8), 64'(0));

    // Saturation: LUT[0]=15, 15 zero samples
    lut_we_i = 1'b1; lut_addr_i = 4'd0; lut_data_i = 4'd15;
    tick();
    lut_we_i = 1'b0;
    for (int i = 0; i < 14; i++) send(32'h00000000, 1'b0, 4'd15);
    check("sat_pending", 64'(valid8), 64'(0));
    send(32'h00000000, 1'b0, 4'd15);
    check("sat_valid",  64'(valid8), 64'(1));
    check("sat_value8", 64'(value8), 64'(32'hE1E1E1E1));
    check("sat_value7", 64'(value7), 64'(28'hFFFFFFF));
    check("sat_err7",   64'(err7),   64'(0));

    // Reset mid-batch
    send(32'h00000000, 1'b0, 4'd3);
    send(32'h00000000, 1'b0, 4'd3);
    #1;
    rst_ni = 1'b0;
    #1;
    check("midrst_valid", 64'(valid8), 64'(0));
    check("midrst_value", 64'(value8), 64'(0));
    check("midrst_err",   64'(err8),   64'(0));
    tick();
    rst_ni = 1'b1;
    tick();
    send(32'h00000000, 1'b0, 4'd1);
    check("postrst_valid", 64'(valid8), 64'(1));
    check("postrst_value", 64'(value8), 64'(32'h09090909));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rbr_thermo_encoder.md
Name: rbr_thermo_encoder

Overview:
- Parametrised, multi-channel successor to the single-channel 8-bit thermometer-to-RBR-code encoder.
- Each channel takes a thermometer code from its sense-amp/comparator bank and derives a level: leading-ones count in strict mode, or total ones count in bubble-tolerant mode.
- The level is mapped through a runtime-programmable LUT. The mapped values are then summed over a programmable number of read samples.
- The result is presented on a registered valid/ready output. The block sits between the array read path and the peripheral result register file.

Parameters:
- NUM_CH, 4, number of independent encoder channels.
- THERM_W, 8, thermometer bits per channel (MSB-first fill).
- OUT_W, 4, width of one LUT entry (mapped code).
- ACC_W, 8, per-channel accumulator/output width.
- LVL_W, $clog2(THERM_W+1), level and LUT address width (derived; do not override).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  a sample is present on therm_i.
- ready_o  out  1  block accepts a sample this cycle.
- therm_i  in  NUM_CH*THERM_W  thermometer codes; channel c occupies bits [c*THERM_W +: THERM_W].
- mode_i  in  1  0 = strict, 1 = bubble-tolerant; sampled with each accepted sample.
- accum_len_i  in  4  samples per batch; 0 is treated as 1; latched on the first sample of a batch.
- lut_we_i  in  1  LUT write strobe.
- lut_addr_i  in  LVL_W  LUT entry index (a level).
- lut_data_i  in  OUT_W  LUT write data.
- valid_o  out  1  batch result available.
- ready_i  in  1  downstream consumes the result.
- value_o  out  NUM_CH*ACC_W  per-channel accumulated mapped values.
- err_o  out  NUM_CH  per-channel sticky invalid-code flag for the batch.

Behaviour:
- Reset (async assert, sync deassert): valid_o=0, value_o=0, err_o=0, accumulators=0, sample counter=0, batch length=1, LUT=default table.
- Default table for THERM_W=8, OUT_W=4, levels 0..8: 9,9,6,6,4,3,2,1,0.
- Default table for any other widths: entry[L] = min(THERM_W-L, 2^OUT_W-1).
- Strict mode, valid code (k MSB ones followed by zeros):
  - level = k.
  - Any other pattern: channel err set and mapped value forced to 0 (LUT bypassed).
- Bubble mode: level = popcount(code); err never set.
- Accept = valid_i && ready_o.
- ready_o = !(valid_o && !ready_i). Stalls only while an unconsumed result is held.
- On accept:
  - Each channel adds its mapped value (zero-extended) to its accumulator. The sum saturates at 2^ACC_W-1.
  - err accumulates as a sticky OR.
  - The counter increments.
- On accept of sample N (N = latched batch length):
  - Output registers load final sums and err.
  - valid_o=1 on the next cycle (latency 1 from final accept).
  - Accumulators, err accumulators and counter clear to 0.
- Output hold: valid_o/value_o/err_o stay stable until valid_o && ready_i. valid_o then drops unless a new batch completes that same cycle; in that case the new result loads and valid_o stays 1.
- Batch length: accum_len_i is captured only when the counter is 0. Changes mid-batch are ignored until the next batch.
- LUT write:
  - Updates the entry on the clock edge.
  - A sample accepted in the same cycle uses the old entry.
  - Writes with lut_addr_i > THERM_W are ignored.
  - Writes are allowed regardless of handshake state.
- Reset mid-batch discards the partial batch and any pending output; the LUT reverts to the default table.

Decomposition:
- Shared package rbr_pkg holds:
  - mode enum (RBR_STRICT, RBR_BUBBLE);
  - function default_lut_entry(level, therm_w, out_w);
  - function therm_is_valid(code);
  - function leading_ones(code);
  - function popcount(code).
- One natural sub-module, rbr_ch_decode: a combinational per-channel code-to-level block with a valid flag. It is instantiated NUM_CH times, and outputs feed a shared LUT read mux per channel.
- Accumulation, counter, LUT storage and handshake live in the top.

Test Plan:
- Strict, accum_len=1, all channels 8'b11110000 -> valid_o one cycle after accept, each value_o lane = 4, err_o=0.
- Strict, ch0=8'b10100000, other channels 8'b11111111 -> ch0 lane=0 and err_o[0]=1; others 0 with err 0. A following batch of valid codes clears err_o.
- Bubble, ch1=8'b10100000 -> level 2 -> ch1 lane=6, err_o[1]=0.
- Accumulation, accum_len=3, codes 00000000, 11000000, 11111110 on ch2 -> single result, ch2 lane=9+6+1=16. accum_len changed to 5 after sample 1 has no effect on this batch.
- LUT write: addr 8 data 15 in the same cycle as accepting 8'b11111111 -> that result 0; next sample -> 15. A write to addr 9 is ignored.
- Backpressure and saturation:
  - ready_i=0 with a result held -> ready_o=0; valid_i held high; no sample lost.
  - accum_len=15 of all-zero codes with LUT[0]=15 and ACC_W=8 -> 225. Repeating with ACC_W=7 saturates to 127.
  - Asserting rst_ni low mid-batch clears everything immediately.
